// File: rtl/ask_demodulator.sv
// Non-coherent ASK demodulator: rectify about DC, integrate per symbol window,
// threshold to one bit. Ports: sample stream in, bit/energy/sat/count/locked out.
module ask_demodulator #(
  parameter int DC_LEVEL        = 10000,
  parameter int SAMPLES_PER_BIT = 64,
  parameter int THRESHOLD       = 200000,
  parameter int ACC_W           = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      sample_in,
  input  logic             sample_valid,
  input  logic             sync,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [ACC_W-1:0] energy_out,
  output logic             sat,
  output logic [15:0]      symbol_count,
  output logic             locked
);

  localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [ACC_W-1:0] TH   = ACC_W'(THRESHOLD);
  localparam logic [15:0]      DC   = 16'(DC_LEVEL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wsat_q, wsat_d;
  logic             bit_q, bit_d;
  logic             vld_q, vld_d;
  logic [ACC_W-1:0] nrg_q, nrg_d;
  logic             sat_q, sat_d;
  logic [15:0]      sym_q, sym_d;

  logic [15:0]      diff;
  logic [ACC_W-1:0] base_acc;
  logic [CNT_W-1:0] base_cnt;
  logic             base_sat;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             sat_nxt;
  logic             take;

  assign diff = (sample_in >= DC) ? sample_in - DC : DC - sample_in;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wsat_d  = wsat_q;
    bit_d   = bit_q;
    vld_d   = 1'b0;
    nrg_d   = nrg_q;
    sat_d   = sat_q;
    sym_d   = sym_q;

    // sync drops any partial window before the coincident sample is added
    base_acc = sync ? '0 : acc_q;
    base_cnt = sync ? '0 : cnt_q;
    base_sat = sync ? 1'b0 : wsat_q;

    sum     = {1'b0, base_acc} + {{(ACC_W-15){1'b0}}, diff};
    acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    sat_nxt = base_sat | sum[ACC_W];
    take    = sample_valid && ((state_q == RUN) || sync);

    if (sync) begin
      state_d = RUN;
      acc_d   = base_acc;
      cnt_d   = base_cnt;
      wsat_d  = base_sat;
    end

    if (take) begin
      if (!sync && (base_cnt == LAST)) begin
        bit_d  = acc_nxt > TH;
        nrg_d  = acc_nxt;
        sat_d  = sat_nxt;
        vld_d  = 1'b1;
        sym_d  = sym_q + 16'd1;
        acc_d  = '0;
        cnt_d  = '0;
        wsat_d = 1'b0;
      end else begin
        acc_d  = acc_nxt;
        cnt_d  = base_cnt + CNT_W'(1);
        wsat_d = sat_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      wsat_q  <= 1'b0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      nrg_q   <= '0;
      sat_q   <= 1'b0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wsat_q  <= wsat_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      nrg_q   <= nrg_d;
      sat_q   <= sat_d;
      sym_q   <= sym_d;
    end
  end

  assign bit_out      = bit_q;
  assign bit_valid    = vld_q;
  assign energy_out   = nrg_q;
  assign sat          = sat_q;
  assign symbol_count = sym_q;
  assign locked       = (state_q == RUN);

endmodule
